// File: rtl/load_store_unit_if.sv
// Core request and memory bus of the load/store unit; names keep the unit's own
// i_/o_ direction, so "slave" is the unit's side and "master" is the core/memory side.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            i_is_store;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_wdata;
    logic            o_ready;
    logic            o_done;
    logic [XLEN-1:0] o_rdata;
    logic            o_misaligned;
    logic            o_illegal;
    logic            o_mem_r_en;
    logic            o_mem_w_en;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_wstrb;
    logic [XLEN-1:0] i_mem_rdata;
    logic            i_mem_ready;

    modport slave (
        input  i_valid, i_is_store, i_funct3, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
        output o_ready, o_done, o_rdata, o_misaligned, o_illegal,
        output o_mem_r_en, o_mem_w_en, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );

    modport master (
        output i_valid, i_is_store, i_funct3, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
        input  o_ready, o_done, o_rdata, o_misaligned, o_illegal,
        input  o_mem_r_en, o_mem_w_en, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, done 2 cycles after accept plus memory stall, faults after 1.
// Backpressure: o_ready only in IDLE; ACCESS holds the memory request until i_mem_ready.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

    typedef struct packed {
        logic            is_store;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t          r_state;
    state_t          w_next;
    req_t            r_req;
    logic            r_misaligned;
    logic            r_illegal;
    logic [XLEN-1:0] r_rdata;

    logic            w_illegal;
    logic            w_misaligned;
    logic            w_accept;
    logic [3:0]      w_strb_lane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;

    logic            w_ready;
    logic            w_done;
    logic            w_r_en;
    logic            w_w_en;
    logic [3:0]      w_wstrb;
    logic            w_flt_mis;
    logic            w_flt_ill;

    // Decode straight from the request pins so IDLE can pick ACCESS or FAULT in one cycle.
    always_comb begin
        w_illegal    = bus.i_is_store ? !(bus.i_funct3 inside {3'b000, 3'b001, 3'b010})
                                      : !(bus.i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_misaligned = ((bus.i_funct3[1:0] == 2'b01) && bus.i_addr[0]) ||
                       ((bus.i_funct3[1:0] == 2'b10) && (bus.i_addr[1:0] != 2'b00));
        w_accept     = (r_state == IDLE) && bus.i_valid;
    end

    always_comb begin
        case (r_req.funct3[1:0])
            2'b00:   w_strb_lane = 4'b0001 << r_req.addr[1:0];
            2'b01:   w_strb_lane = 4'b0011 << r_req.addr[1:0];
            default: w_strb_lane = 4'b1111;
        endcase
    end

    always_comb begin
        w_byte = bus.i_mem_rdata[{r_req.addr[1:0], 3'b000} +: 8];
        w_half = r_req.addr[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
        case (r_req.funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = bus.i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_done    = 1'b0;
        w_r_en    = 1'b0;
        w_w_en    = 1'b0;
        w_wstrb   = 4'b0000;
        w_flt_mis = 1'b0;
        w_flt_ill = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.i_valid) begin
                    w_next = (w_illegal || w_misaligned) ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                w_r_en  = !r_req.is_store;
                w_w_en  = r_req.is_store;
                w_wstrb = r_req.is_store ? w_strb_lane : 4'b0000;
                if (bus.i_mem_ready) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            FAULT: begin
                w_done    = 1'b1;
                w_flt_mis = r_misaligned;
                w_flt_ill = r_illegal;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_rdata doubles as the visible result so it naturally holds through IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req        <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_req.is_store <= bus.i_is_store;
                r_req.funct3   <= bus.i_funct3;
                r_req.addr     <= bus.i_addr;
                r_req.wdata    <= bus.i_wdata;
                r_illegal      <= w_illegal;
                r_misaligned   <= w_misaligned && !w_illegal;
                if (w_illegal || w_misaligned) begin
                    r_rdata <= '0;
                end
            end
            if ((r_state == ACCESS) && bus.i_mem_ready) begin
                r_rdata <= r_req.is_store ? '0 : w_load;
            end
        end
    end

    assign bus.o_ready      = w_ready;
    assign bus.o_done       = w_done;
    assign bus.o_rdata      = r_rdata;
    assign bus.o_misaligned = w_flt_mis;
    assign bus.o_illegal    = w_flt_ill;
    assign bus.o_mem_r_en   = w_r_en;
    assign bus.o_mem_w_en   = w_w_en;
    assign bus.o_mem_wstrb  = w_wstrb;
    assign bus.o_mem_addr   = {2'b00, r_req.addr[XLEN-1:2]};
    assign bus.o_mem_wdata  = r_req.wdata << {r_req.addr[1:0], 3'b000};
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: a byte-level memory model predicts every
// completion and memory transaction; separate monitors pop and compare them.
module tb_load_store_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        is_wr;
    } memx_t;

    resp_t      exp_resp[$];
    memx_t      exp_mem[$];
    logic [7:0] ref_mem [512];
    logic [31:0] mem_w  [128];
    int n_cmp     = 0;
    int n_err     = 0;
    int stall_cfg = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        mem_w[idx] = v;
        for (int k = 0; k < 4; k++) ref_mem[4*idx + k] = v[8*k +: 8];
    endtask

    // Memory responder: stalls stall_cfg cycles, checks each request cycle against the model.
    initial begin : memory
        int    cnt;
        int    stall;
        logic  active;
        memx_t cur;
        logic [31:0] mask;
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = '0;
        cnt = 0; stall = 0; active = 1'b0;
        cur = '{addr: 0, strb: 0, data: 0, is_wr: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0; active = 1'b0; bus.i_mem_ready = 1'b0;
            end else if (bus.o_mem_r_en || bus.o_mem_w_en) begin
                if (!active) begin
                    active = 1'b1; cnt = 0; stall = stall_cfg;
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected_en", {31'b0, bus.o_mem_r_en | bus.o_mem_w_en}, 32'd0);
                        cur = '{addr: bus.o_mem_addr, strb: 0, data: 0, is_wr: bus.o_mem_w_en};
                    end else begin
                        cur = exp_mem.pop_front();
                    end
                end
                mask = '0;
                for (int k = 0; k < 4; k++) if (cur.strb[k]) mask[8*k +: 8] = 8'hFF;
                check("mem_addr",  bus.o_mem_addr, cur.addr);
                check("mem_w_en",  {31'b0, bus.o_mem_w_en}, {31'b0, cur.is_wr});
                check("mem_r_en",  {31'b0, bus.o_mem_r_en}, {31'b0, !cur.is_wr});
                if (cur.is_wr) begin
                    check("mem_wstrb", {28'b0, bus.o_mem_wstrb}, {28'b0, cur.strb});
                    check("mem_wdata", bus.o_mem_wdata & mask, cur.data);
                end
                if (cnt < stall) begin
                    bus.i_mem_ready = 1'b0;
                    cnt++;
                end else begin
                    bus.i_mem_ready = 1'b1;
                    if (bus.o_mem_w_en) begin
                        for (int k = 0; k < 4; k++)
                            if (bus.o_mem_wstrb[k])
                                mem_w[bus.o_mem_addr[6:0]][8*k +: 8] = bus.o_mem_wdata[8*k +: 8];
                    end else begin
                        bus.i_mem_rdata = mem_w[bus.o_mem_addr[6:0]];
                    end
                end
            end else begin
                active = 1'b0;
                bus.i_mem_ready = 1'b0;
                bus.i_mem_rdata = $urandom;
            end
        end
    end

    // Completion monitor: every o_done must match the oldest predicted response.
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_done) begin
                if (exp_resp.size() == 0) begin
                    check("done_unexpected", {31'b0, bus.o_done}, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    check("rdata",      bus.o_rdata, r.rdata);
                    check("misaligned", {31'b0, bus.o_misaligned}, {31'b0, r.mis});
                    check("illegal",    {31'b0, bus.o_illegal},    {31'b0, r.ill});
                end
            end
        end
    end

    // Predict the outcome from RV32I rules on a byte-addressed memory, then drive it.
    task automatic issue(input logic is_st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int stall,
                         input logic use_exp, input logic [31:0] exp_val);
        resp_t r;
        memx_t m;
        int    size;
        int    cyc;
        logic  ill, mis;
        logic [31:0] v;
        ill  = is_st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = !ill && ((a % size) != 0);
        r.mis = mis; r.ill = ill; r.rdata = '0;
        if (!ill && !mis) begin
            m.addr = a >> 2; m.is_wr = is_st; m.strb = '0; m.data = '0;
            if (is_st) begin
                for (int i = 0; i < size; i++) begin
                    ref_mem[(a + i) % 512] = wd[8*i +: 8];
                    m.strb[(a + i) % 4] = 1'b1;
                    m.data[8*((a + i) % 4) +: 8] = wd[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[(a + i) % 512]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
                r.rdata = v;
            end
            exp_mem.push_back(m);
        end
        if (use_exp) r.rdata = exp_val;
        exp_resp.push_back(r);
        stall_cfg = stall;

        cyc = 0;
        while (!bus.o_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check("ready_before_issue", {31'b0, bus.o_ready}, 32'd1);
        bus.i_valid = 1'b1; bus.i_is_store = is_st; bus.i_funct3 = f3;
        bus.i_addr = a; bus.i_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.o_done) check("busy_ready", {31'b0, bus.o_ready}, 32'd0);
        end while (!bus.o_done && cyc < 200);
        check("latency", cyc, (ill || mis) ? 32'd1 : 32'(2 + stall));
        bus.i_valid = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'b0, bus.o_done}, 32'd0);
        check("ready_after",    {31'b0, bus.o_ready}, 32'd1);
        check("rdata_hold",     bus.o_rdata, r.rdata);
    endtask

    // Store caught by reset mid-ACCESS: it must never reach memory, so the model is left untouched.
    task automatic reset_mid_access(input logic [31:0] a);
        memx_t m;
        m.addr = a >> 2; m.is_wr = 1'b1; m.strb = 4'hF; m.data = 32'hDEAD_BEEF;
        exp_mem.push_back(m);
        stall_cfg = 1000;
        bus.i_valid = 1'b1; bus.i_is_store = 1'b1; bus.i_funct3 = 3'd2;
        bus.i_addr = a; bus.i_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_pre_w_en", {31'b0, bus.o_mem_w_en}, 32'd1);
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_w_en",   {31'b0, bus.o_mem_w_en}, 32'd0);
        check("rst_r_en",   {31'b0, bus.o_mem_r_en}, 32'd0);
        check("rst_wstrb",  {28'b0, bus.o_mem_wstrb}, 32'd0);
        check("rst_addr",   bus.o_mem_addr, 32'd0);
        check("rst_rdata",  bus.o_rdata, 32'd0);
        check("rst_done",   {31'b0, bus.o_done}, 32'd0);
        exp_mem.delete();
        stall_cfg = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", {31'b0, bus.o_ready}, 32'd1);
        check("rst_no_stale_done", {31'b0, bus.o_done}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] a;
        logic [2:0]  f3;
        bus.i_valid = 1'b0; bus.i_is_store = 1'b0; bus.i_funct3 = '0;
        bus.i_addr = '0; bus.i_wdata = '0;
        for (int w = 0; w < 128; w++) set_word(w, $urandom);

        repeat (3) @(negedge clk);
        check("reset_done",   {31'b0, bus.o_done}, 32'd0);
        check("reset_mis",    {31'b0, bus.o_misaligned}, 32'd0);
        check("reset_ill",    {31'b0, bus.o_illegal}, 32'd0);
        check("reset_r_en",   {31'b0, bus.o_mem_r_en}, 32'd0);
        check("reset_w_en",   {31'b0, bus.o_mem_w_en}, 32'd0);
        check("reset_wstrb",  {28'b0, bus.o_mem_wstrb}, 32'd0);
        check("reset_rdata",  bus.o_rdata, 32'd0);
        check("reset_addr",   bus.o_mem_addr, 32'd0);
        check("reset_wdata",  bus.o_mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'b0, bus.o_ready}, 32'd1);

        set_word(32'h40, 32'h80FF_1234);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b1, 32'hFFFF_FF80);
        issue(1'b0, 3'b101, 32'h102, 32'h0, 0, 1'b1, 32'h0000_80FF);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 0, 1'b1, 32'hFFFF_80FF);
        issue(1'b1, 3'b000, 32'h21,  32'h0000_00AB, 3, 1'b0, 32'h0);
        issue(1'b0, 3'b000, 32'h21,  32'h0, 1, 1'b1, 32'hFFFF_FFAB);
        issue(1'b0, 3'b010, 32'h6,   32'h0, 0, 1'b0, 32'h0);
        issue(1'b1, 3'b011, 32'h40,  32'h1234_5678, 0, 1'b0, 32'h0);

        reset_mid_access(32'h80);
        issue(1'b0, 3'b010, 32'h80, 32'h0, 0, 1'b0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom);
            a  = $urandom_range(0, 511);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 9);
            issue(1'($urandom), f3, a, $urandom, $urandom_range(0, 3), 1'b0, 32'h0);
        end

        repeat (2) @(negedge clk);
        check("resp_queue_drained", exp_resp.size(), 32'd0);
        check("mem_queue_drained",  exp_mem.size(),  32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data/address width; only 32 is supported.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1, core request strobe, sampled only in IDLE.
REQ-005 SHALL have port i_is_store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port i_funct3, input, 3, RV32I size/sign code.
REQ-007 SHALL have port i_addr, input, XLEN, effective byte address.
REQ-008 SHALL have port i_wdata, input, XLEN, store data (rs2), LSB-aligned.
REQ-009 SHALL have port o_ready, output, 1, high only in IDLE.
REQ-010 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_rdata, output, XLEN, load result, extended.
REQ-012 SHALL have port o_misaligned, output, 1, qualifies o_done as an alignment fault.
REQ-013 SHALL have port o_illegal, output, 1, qualifies o_done as an unsupported funct3.
REQ-014 SHALL have port o_mem_r_en, output, 1, memory read enable.
REQ-015 SHALL have port o_mem_w_en, output, 1, memory write enable.
REQ-016 SHALL have port o_mem_addr, output, XLEN, word index equal to i_addr >> 2.
REQ-017 SHALL have port o_mem_wdata, output, XLEN, store data shifted to its byte lane.
REQ-018 SHALL have port o_mem_wstrb, output, 4, byte-lane write enables.
REQ-019 SHALL have port i_mem_rdata, input, XLEN, memory read word.
REQ-020 SHALL have port i_mem_ready, input, 1, memory accepts the write or returns read data this cycle.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, DONE, FAULT; reset state is IDLE.
REQ-022 SHALL, in IDLE with i_valid=1, register i_is_store, i_funct3, i_addr and i_wdata; decode happens in the same cycle.
REQ-023 SHALL support loads with funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; all other load codes are illegal.
REQ-024 SHALL support stores with funct3 000 SB, 001 SH and 010 SW; all other store codes are illegal.
REQ-025 SHALL go IDLE->FAULT with no memory enable asserted when the request is illegal (priority) or misaligned (half with addr[0]=1, word with addr[1:0]!=0).
REQ-026 SHALL go IDLE->ACCESS otherwise.
REQ-027 SHALL, in ACCESS, hold o_mem_r_en (load) or o_mem_w_en (store), o_mem_addr, o_mem_wdata and o_mem_wstrb stable until i_mem_ready=1, then go to DONE; there is no timeout.
REQ-028 SHALL generate wstrb values: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-029 SHALL generate store data: o_mem_wdata = i_wdata << (8*addr[1:0]), with bytes outside the strobe don't-care.
REQ-030 SHALL, for loads, capture i_mem_rdata in the cycle i_mem_ready=1.
REQ-031 SHALL select the load byte/half by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through.
REQ-032 SHALL, in DONE, pulse o_done=1 for exactly one cycle; o_rdata is valid in DONE for loads and 0 for stores; next state is IDLE.
REQ-033 SHALL, in FAULT, pulse o_done=1 for one cycle with o_misaligned or o_illegal=1 (exactly one of them) and o_rdata=0; next state is IDLE.
REQ-034 SHALL ignore i_valid outside IDLE; back-to-back requests give a minimum period of 3 cycles (IDLE, ACCESS, DONE) when i_mem_ready=1 immediately.
REQ-035 SHALL deassert o_mem_r_en, o_mem_w_en and o_mem_wstrb in every state except ACCESS.
REQ-036 SHALL keep o_rdata at its last value while in IDLE.

Reset
REQ-037 SHALL, on i_rst_n=0 (async), immediately force state IDLE.
REQ-038 SHALL, on reset, force o_done, o_misaligned, o_illegal, o_mem_r_en, o_mem_w_en = 0.
REQ-039 SHALL, on reset, force o_mem_wstrb = 0000 and o_rdata, o_mem_addr, o_mem_wdata = 0.
REQ-040 SHALL, when reset is asserted mid-ACCESS, drop the memory enables in the same instant and write nothing afterwards.
REQ-041 SHALL make o_ready=1 in the first cycle after reset release.

Verification
REQ-042 SHALL cover LB at addr 0x103 with mem word 0x80FF_1234 and ready=1 -> o_rdata=0xFFFF_FF80, o_done one cycle, 3-cycle total.
REQ-043 SHALL cover LHU at addr 0x102 with word 0x80FF_1234 -> o_rdata=0x0000_80FF; LH at the same address -> 0xFFFF_80FF.
REQ-044 SHALL cover SB at addr 0x21 with i_wdata=0x0000_00AB -> o_mem_addr=0x8, wstrb=0010, wdata[15:8]=0xAB, w_en held through 3 stall cycles until ready.
REQ-045 SHALL cover LW at addr 0x6 -> FAULT with o_misaligned=1 and no r_en/w_en ever asserted.
REQ-046 SHALL cover store with funct3=011 -> o_illegal=1, o_misaligned=0, no w_en.
REQ-047 SHALL cover reset pulled low during ACCESS with ready=0 -> enables 0 immediately, o_ready=1 after release, no stale o_done.
